// File: rtl/carcontrol_vjtag_scan_master.sv
// rtl/carcontrol_vjtag_scan_master.sv - virtual-JTAG scan master: one UIR/CDR/SDR/UDR/RTI pass per command
// Each scan state spans whole TCK periods generated from clk; results are held until the consumer takes them.
module carcontrol_vjtag_scan_master #(
   parameter int TCK_DIV = 2,
   parameter int DR_W    = 38
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_ir,
   input  logic [DR_W-1:0] cmd_dr,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DR_W-1:0] rsp_dr,
   output logic [1:0]      rsp_ir_out,
   output logic            vji_tck,
   output logic            vji_tdi,
   output logic            vji_uir,
   output logic            vji_cdr,
   output logic            vji_sdr,
   output logic            vji_udr,
   output logic            vji_rti,
   output logic [1:0]      vji_ir_in,
   input  logic            vji_tdo,
   input  logic [1:0]      vji_ir_out
);

   localparam int            BIT_W    = (DR_W > 1) ? $clog2(DR_W) : 1;
   localparam logic [8:0]    RISE_AT  = 9'(TCK_DIV - 1);
   localparam logic [8:0]    LAST_AT  = 9'(2 * TCK_DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DR_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP
   } state_t;

   state_t            state_q;
   logic [8:0]        div_q;
   logic [BIT_W-1:0]  bit_q;
   logic [DR_W-1:0]   dr_q;
   logic [DR_W-1:0]   rsp_dr_q;
   logic [1:0]        rsp_ir_q;
   logic [1:0]        ir_in_q;
   logic              cmd_ready_q;
   logic              rsp_valid_q;
   logic              tck_q;
   logic              tdi_q;
   logic              uir_q, cdr_q, sdr_q, udr_q, rti_q;

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_dr     = rsp_dr_q;
   assign rsp_ir_out = rsp_ir_q;
   assign vji_tck    = tck_q;
   assign vji_tdi    = tdi_q;
   assign vji_uir    = uir_q;
   assign vji_cdr    = cdr_q;
   assign vji_sdr    = sdr_q;
   assign vji_udr    = udr_q;
   assign vji_rti    = rti_q;
   assign vji_ir_in  = ir_in_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         bit_q       <= '0;
         dr_q        <= '0;
         rsp_dr_q    <= '0;
         rsp_ir_q    <= '0;
         ir_in_q     <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         tck_q       <= 1'b0;
         tdi_q       <= 1'b0;
         uir_q       <= 1'b0;
         cdr_q       <= 1'b0;
         sdr_q       <= 1'b0;
         udr_q       <= 1'b0;
         rti_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  state_q     <= S_UIR;
                  cmd_ready_q <= 1'b0;
                  ir_in_q     <= cmd_ir;
                  dr_q        <= cmd_dr;
                  div_q       <= '0;
                  bit_q       <= '0;
                  tck_q       <= 1'b0;
                  uir_q       <= 1'b1;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: begin
               if (div_q == LAST_AT) begin
                  // period boundary: TCK falls and the next period's strobes/TDI take effect together
                  div_q <= '0;
                  tck_q <= 1'b0;
                  case (state_q)
                     S_UIR: begin
                        state_q <= S_CDR;
                        uir_q   <= 1'b0;
                        cdr_q   <= 1'b1;
                     end
                     S_CDR: begin
                        state_q <= S_SDR;
                        cdr_q   <= 1'b0;
                        sdr_q   <= 1'b1;
                        tdi_q   <= dr_q[0];
                        dr_q    <= dr_q >> 1;
                     end
                     S_SDR: begin
                        if (bit_q == LAST_BIT) begin
                           state_q <= S_UDR;
                           sdr_q   <= 1'b0;
                           udr_q   <= 1'b1;
                           tdi_q   <= 1'b0;
                        end else begin
                           bit_q <= bit_q + 1'b1;
                           tdi_q <= dr_q[0];
                           dr_q  <= dr_q >> 1;
                        end
                     end
                     S_UDR: begin
                        state_q <= S_RTI;
                        udr_q   <= 1'b0;
                        rti_q   <= 1'b1;
                     end
                     S_RTI: begin
                        state_q     <= S_RSP;
                        rti_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                     end
                     default: ;
                  endcase
               end else begin
                  div_q <= div_q + 9'd1;
                  if (div_q == RISE_AT) begin
                     tck_q <= 1'b1;
                     if (state_q == S_UIR) rsp_ir_q <= vji_ir_out;
                     // shifting in from the top leaves the first captured bit in the LSB
                     if (state_q == S_SDR) rsp_dr_q <= {vji_tdo, rsp_dr_q[DR_W-1:1]};
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_carcontrol_vjtag_scan_master.sv
// tb/tb_carcontrol_vjtag_scan_master.sv - directed bench for carcontrol_vjtag_scan_master
module tb_carcontrol_vjtag_scan_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b1;
   logic [1:0]  cmd_ir = '0, rsp_ir_out, ir_in, ir_out = '0;
   logic [37:0] cmd_dr = '0, rsp_dr;
   logic        tck, tdi, uir, cdr, sdr, udr, rti, tdo;
   logic        tdo_lb = 1'b0;
   int          tdo_mode = 0;

   always @(posedge tck) tdo_lb <= tdi;
   always_comb tdo = (tdo_mode == 0) ? tdo_lb : (tdo_mode == 1);

   carcontrol_vjtag_scan_master #(.TCK_DIV(2), .DR_W(38)) dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .vji_tck(tck), .vji_tdi(tdi),
      .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti),
      .vji_ir_in(ir_in), .vji_tdo(tdo), .vji_ir_out(ir_out));

   logic       cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1;
   logic [1:0] cmd_ir1 = 2'b10, rsp_ir_out1, ir_in1;
   logic [7:0] cmd_dr1 = '0, rsp_dr1;
   logic       tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;

   carcontrol_vjtag_scan_master #(.TCK_DIV(1), .DR_W(8)) dut1 (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_ir(cmd_ir1), .cmd_dr(cmd_dr1), .rsp_valid(rsp_valid1), .rsp_ready(1'b1),
      .rsp_dr(rsp_dr1), .rsp_ir_out(rsp_ir_out1), .vji_tck(tck1), .vji_tdi(tdi1),
      .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1),
      .vji_ir_in(ir_in1), .vji_tdo(tdi1), .vji_ir_out(2'b01));

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] dr;
      int          mode;
      logic [1:0]  irout;
      logic [37:0] exp_dr;
   } vec_t;

   vec_t vecs[5];

   int cyc, first_u, first_c, first_s, first_d, first_r;
   int n_u, n_c, n_s, n_d, n_r, hot_err, stab_err;
   logic [37:0] held_dr;

   initial begin
      // mode 0: TDO is TDI delayed one TCK period; 1: tied high; 2: tied low
      vecs[0] = '{ir: 2'b01, dr: 38'h2A_5A5A_A5A5, mode: 0, irout: 2'b11, exp_dr: 38'h14_B4B5_4B4A};
      vecs[1] = '{ir: 2'b11, dr: 38'h00_1234_5678, mode: 1, irout: 2'b10, exp_dr: 38'h3F_FFFF_FFFF};
      vecs[2] = '{ir: 2'b10, dr: 38'h3F_FFFF_FFFF, mode: 2, irout: 2'b01, exp_dr: 38'h00_0000_0000};
      vecs[3] = '{ir: 2'b00, dr: 38'h3F_FFFF_FFFF, mode: 0, irout: 2'b00, exp_dr: 38'h3F_FFFF_FFFE};
      vecs[4] = '{ir: 2'b01, dr: 38'h20_0000_0001, mode: 0, irout: 2'b10, exp_dr: 38'h00_0000_0002};

      #12;
      chk("reset_cmd_ready", cmd_ready, 0);
      chk("reset_rsp", {rsp_valid, rsp_dr, rsp_ir_out}, 0);
      chk("reset_vji", {tck, tdi, uir, cdr, sdr, udr, rti, ir_in}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      chk("ready_after_reset", cmd_ready, 1);

      foreach (vecs[i]) begin
         tdo_mode  = vecs[i].mode;
         ir_out    = vecs[i].irout;
         cmd_ir    = vecs[i].ir;
         cmd_dr    = vecs[i].dr;
         cmd_valid = 1'b1;
         chk($sformatf("v%0d_ready", i), cmd_ready, 1);
         step();
         cmd_valid = 1'b0;
         cmd_ir    = ~vecs[i].ir;
         cmd_dr    = ~vecs[i].dr;
         cyc = 1;
         first_u = 0; first_c = 0; first_s = 0; first_d = 0; first_r = 0;
         n_u = 0; n_c = 0; n_s = 0; n_d = 0; n_r = 0; hot_err = 0;
         while (!rsp_valid && cyc < 400) begin
            if (uir) begin n_u++; if (first_u == 0) first_u = cyc; end
            if (cdr) begin n_c++; if (first_c == 0) first_c = cyc; end
            if (sdr) begin n_s++; if (first_s == 0) first_s = cyc; end
            if (udr) begin n_d++; if (first_d == 0) first_d = cyc; end
            if (rti) begin n_r++; if (first_r == 0) first_r = cyc; end
            if ($countones({uir, cdr, sdr, udr, rti}) != 1) hot_err++;
            if (ir_in !== vecs[i].ir) hot_err++;
            step();
            cyc++;
         end
         chk($sformatf("v%0d_latency", i), cyc, 169);
         chk($sformatf("v%0d_rsp_dr", i), rsp_dr, vecs[i].exp_dr);
         chk($sformatf("v%0d_rsp_ir_out", i), rsp_ir_out, vecs[i].irout);
         chk($sformatf("v%0d_strobe_order", i), {8'(first_u), 8'(first_c), 8'(first_s), 8'(first_d), 8'(first_r)},
             {8'd1, 8'd5, 8'd9, 8'd161, 8'd165});
         chk($sformatf("v%0d_strobe_len", i), {8'(n_u), 8'(n_c), 8'(n_s), 8'(n_d), 8'(n_r)},
             {8'd4, 8'd4, 8'd152, 8'd4, 8'd4});
         chk($sformatf("v%0d_onehot_ir", i), hot_err, 0);
         chk($sformatf("v%0d_rsp_idle_vji", i), {tck, tdi, uir, cdr, sdr, udr, rti, cmd_ready}, 0);
         step();
         chk($sformatf("v%0d_after_hs", i), {rsp_valid, cmd_ready}, 2'b01);
      end

      // consumer stalls: response must hold and a new command must be ignored
      tdo_mode = 1; ir_out = 2'b10; cmd_ir = 2'b01; cmd_dr = 38'h15_5555_5555;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      cyc = 1;
      while (!rsp_valid && cyc < 400) begin step(); cyc++; end
      chk("stall_latency", cyc, 169);
      held_dr = rsp_dr;
      chk("stall_rsp_dr", held_dr, 38'h3F_FFFF_FFFF);
      cmd_valid = 1'b1; cmd_ir = 2'b10; cmd_dr = '0;
      stab_err = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (rsp_valid !== 1'b1 || rsp_dr !== held_dr || rsp_ir_out !== 2'b10 ||
             cmd_ready !== 1'b0 || ir_in !== 2'b01) stab_err++;
      end
      chk("stall_stable", stab_err, 0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      chk("stall_release", {rsp_valid, cmd_ready}, 2'b01);

      // reset in the middle of SDR period 10 (cycles 49..52 after acceptance)
      cmd_dr = 38'h0F_0F0F_0F0F;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int k = 1; k < 50; k++) step();
      chk("pre_abort_sdr", {sdr, uir, rti}, 3'b100);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_vji", {tck, tdi, uir, cdr, sdr, udr, rti, ir_in}, 0);
      chk("abort_ctl", {cmd_ready, rsp_valid, rsp_dr, rsp_ir_out}, 0);
      step();
      step();
      reset_n = 1'b1;
      #1;
      chk("abort_ready_low", cmd_ready, 0);
      step();
      chk("abort_ready_high", cmd_ready, 1);
      stab_err = 0;
      for (int k = 0; k < 200; k++) begin
         step();
         if (rsp_valid || uir || cdr || sdr || udr || rti || tck) stab_err++;
      end
      chk("abort_no_rsp", stab_err, 0);

      // TCK_DIV=1, DR_W=8: back-to-back scans with the consumer always ready
      begin
         int acc[2], hs[2], na, nh, tck_err, highs;
         logic [7:0] got[2];
         logic exp_hi, exp_lo;
         na = 0; nh = 0; tck_err = 0; highs = 0; exp_hi = 0; exp_lo = 0;
         acc = '{0, 0}; hs = '{0, 0}; got = '{8'h00, 8'h00};
         cmd_dr1 = 8'hA5;
         cmd_valid1 = 1'b1;
         for (int n = 0; n < 90; n++) begin
            if (exp_hi && !tck1) tck_err++;
            if (exp_lo && tck1) tck_err++;
            exp_hi = (uir1 | cdr1 | sdr1 | udr1 | rti1) && !tck1;
            exp_lo = tck1;
            if (tck1) highs++;
            if (rsp_valid1 && nh < 2) begin hs[nh] = n; got[nh] = rsp_dr1; nh++; end
            if (cmd_valid1 && cmd_ready1 && na < 2) begin acc[na] = n; na++; end
            step();
            if (na == 1) cmd_dr1 = 8'h3C;
            if (na == 2) cmd_valid1 = 1'b0;
         end
         chk("d1_counts", {8'(na), 8'(nh)}, {8'd2, 8'd2});
         chk("d1_latency", hs[0] - acc[0], 25);
         chk("d1_back_to_back", acc[1] - hs[0], 1);
         chk("d1_rsp0", got[0], 8'hA5);
         chk("d1_rsp1", got[1], 8'h3C);
         chk("d1_tck_shape", tck_err, 0);
         chk("d1_tck_highs", highs, 24);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
